pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_pkg.sv | 29 ++
 rtl/pipe_stage_reg_if.sv | 24 ++
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: skid-stage state encoding and the bundle widths
// used by every stage register in the datapath.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipeState_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 147;
  localparam int EX_MEM_W = 107;
  localparam int MEM_WB_W = 71;

  function automatic logic [1:0] occOf(input pipeState_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_BUSY:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle channel through one pipeline stage register, plus flush and
// occupancy status.
interface pipe_stage_reg_if #(parameter int DATA_W = 64);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a 2-entry skid buffer: full throughput under stall,
// synchronous flush to bubbles, all outputs driven straight from flops.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic             CLK,
  input  logic             RSTn,
  pipe_stage_reg_if.slave  bus
);

  pipeState_e        stateR;
  pipeState_e        nextStateS;
  logic [DATA_W-1:0] mainR;
  logic [DATA_W-1:0] skidR;
  logic [DATA_W-1:0] mainNextS;
  logic [DATA_W-1:0] skidNextS;
  logic              inReadyR;
  logic              outValidR;
  logic [1:0]        occR;
  logic              inReadyNextS;
  logic              outValidNextS;
  logic [1:0]        occNextS;
  logic              acceptS;
  logic              popS;

  // A bundle offered during flush is dropped, never accepted.
  assign acceptS = bus.in_valid & inReadyR & ~bus.flush;
  assign popS    = outValidR & bus.out_ready;

  assign bus.in_ready  = inReadyR;
  assign bus.out_valid = outValidR;
  assign bus.out_data  = mainR;
  assign bus.occupancy = occR;

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stateR <= ST_EMPTY;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next-state logic and data moves; skid always holds the younger entry.
  always_comb begin
    nextStateS = stateR;
    mainNextS  = mainR;
    skidNextS  = skidR;
    if (bus.flush) begin
      nextStateS = ST_EMPTY;
      mainNextS  = BUBBLE;
      skidNextS  = BUBBLE;
    end else begin
      case (stateR)
        ST_EMPTY: begin
          if (acceptS) begin
            nextStateS = ST_BUSY;
            mainNextS  = bus.in_data;
          end else begin
            nextStateS = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (acceptS && popS) begin
            mainNextS = bus.in_data;
          end else if (acceptS) begin
            nextStateS = ST_FULL;
            skidNextS  = bus.in_data;
          end else if (popS) begin
            nextStateS = ST_EMPTY;
            mainNextS  = BUBBLE;
          end else begin
            nextStateS = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (popS) begin
            nextStateS = ST_BUSY;
            mainNextS  = skidR;
            skidNextS  = BUBBLE;
          end else begin
            nextStateS = ST_FULL;
          end
        end
        default: begin
          nextStateS = ST_EMPTY;
          mainNextS  = BUBBLE;
          skidNextS  = BUBBLE;
        end
      endcase
    end
  end

  // Output decode from the next state, so every status output is a flop.
  always_comb begin
    inReadyNextS  = (nextStateS != ST_FULL);
    outValidNextS = (nextStateS != ST_EMPTY);
    occNextS      = occOf(nextStateS);
  end

  // Data and status registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mainR     <= BUBBLE;
      skidR     <= BUBBLE;
      inReadyR  <= 1'b1;
      outValidR <= 1'b0;
      occR      <= 2'd0;
    end else begin
      mainR     <= mainNextS;
      skidR     <= skidNextS;
      inReadyR  <= inReadyNextS;
      outValidR <= outValidNextS;
      occR      <= occNextS;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, async-reset sequence,
// and randomized traffic on 32- and 107-bit instances against a queue model.
module tb_pipe_stage_reg;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32))  busA ();
  pipe_stage_reg_if #(.DATA_W(107)) busB ();

  pipe_stage_reg #(.DATA_W(32))  dutA (.CLK(clk), .RSTn(rstN), .bus(busA.slave));
  pipe_stage_reg #(.DATA_W(107)) dutB (.CLK(clk), .RSTn(rstN), .bus(busB.slave));

  typedef struct packed {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        expV;
    logic [31:0] expD;
    logic        expR;
    logic [1:0]  expO;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic chkA(input string nm, input logic v, input logic [31:0] d,
                      input logic r, input logic [1:0] o);
    chk({nm, "_valid"}, 128'(busA.out_valid), 128'(v));
    chk({nm, "_data"},  128'(busA.out_data),  128'(d));
    chk({nm, "_ready"}, 128'(busA.in_ready),  128'(r));
    chk({nm, "_occ"},   128'(busA.occupancy), 128'(o));
  endtask

  logic [127:0] qa [$];
  logic [127:0] qb [$];

  initial begin
    logic         stallA, stallB;
    logic [127:0] prevA, prevB, r128, dA, dB;
    logic         ivA, orA, flA, ivB, orB, flB;

    //            iv  data        ordy fl   expV expD        expR expO
    vecs[0]  = '{1'b1, 32'h1,     1'b1, 1'b0, 1'b1, 32'h1,    1'b1, 2'd1};
    vecs[1]  = '{1'b1, 32'h2,     1'b1, 1'b0, 1'b1, 32'h2,    1'b1, 2'd1};
    vecs[2]  = '{1'b1, 32'h3,     1'b1, 1'b0, 1'b1, 32'h3,    1'b1, 2'd1};
    vecs[3]  = '{1'b0, 32'hDEAD,  1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 2'd0};
    vecs[4]  = '{1'b1, 32'hA,     1'b0, 1'b0, 1'b1, 32'hA,    1'b1, 2'd1};
    vecs[5]  = '{1'b1, 32'hB,     1'b0, 1'b0, 1'b1, 32'hA,    1'b0, 2'd2};
    vecs[6]  = '{1'b1, 32'hD,     1'b0, 1'b0, 1'b1, 32'hA,    1'b0, 2'd2};
    vecs[7]  = '{1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA,    1'b0, 2'd2};
    vecs[8]  = '{1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hA,    1'b0, 2'd2};
    vecs[9]  = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 32'hB,    1'b1, 2'd1};
    vecs[10] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 2'd0};
    vecs[11] = '{1'b1, 32'hA,     1'b0, 1'b0, 1'b1, 32'hA,    1'b1, 2'd1};
    vecs[12] = '{1'b1, 32'hB,     1'b0, 1'b0, 1'b1, 32'hA,    1'b0, 2'd2};
    vecs[13] = '{1'b1, 32'hC,     1'b0, 1'b1, 1'b0, 32'h0,    1'b1, 2'd0};
    vecs[14] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 2'd0};
    vecs[15] = '{1'b1, 32'h55,    1'b1, 1'b0, 1'b1, 32'h55,   1'b1, 2'd1};
    vecs[16] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 2'd0};
    vecs[17] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 2'd0};
    vecs[18] = '{1'b1, 32'h7,     1'b0, 1'b0, 1'b1, 32'h7,    1'b1, 2'd1};
    vecs[19] = '{1'b1, 32'h8,     1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 2'd0};
    vecs[20] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 2'd0};

    busA.in_valid = 1'b0; busA.in_data = 32'h0; busA.out_ready = 1'b0; busA.flush = 1'b0;
    busB.in_valid = 1'b0; busB.in_data = 107'h0; busB.out_ready = 1'b0; busB.flush = 1'b0;

    repeat (3) stepClk();
    chkA("reset", 1'b0, 32'h0, 1'b1, 2'd0);
    rstN = 1'b1;
    stepClk();
    chkA("post_reset", 1'b0, 32'h0, 1'b1, 2'd0);

    for (int i = 0; i < 21; i++) begin
      busA.in_valid  = vecs[i].iv;
      busA.in_data   = vecs[i].d;
      busA.out_ready = vecs[i].ordy;
      busA.flush     = vecs[i].fl;
      stepClk();
      chkA($sformatf("vec%0d", i), vecs[i].expV, vecs[i].expD, vecs[i].expR, vecs[i].expO);
    end

    // Async reset in the middle of a stall, away from any clock edge.
    busA.in_valid = 1'b1; busA.in_data = 32'hE1; busA.out_ready = 1'b0; busA.flush = 1'b0;
    stepClk();
    busA.in_data = 32'hE2;
    stepClk();
    busA.in_valid = 1'b0;
    chkA("pre_async", 1'b1, 32'hE1, 1'b0, 2'd2);
    #2 rstN = 1'b0;
    #1 chkA("async_reset", 1'b0, 32'h0, 1'b1, 2'd0);
    stepClk();
    rstN = 1'b1;
    stepClk();
    chkA("after_async", 1'b0, 32'h0, 1'b1, 2'd0);

    // Randomized traffic on both widths against a FIFO-of-held-entries model.
    stallA = 1'b0; stallB = 1'b0; prevA = '0; prevB = '0;
    for (int c = 0; c < 10000; c++) begin
      chk("rndA_valid", 128'(busA.out_valid), 128'(qa.size() != 0));
      chk("rndA_data",  128'(busA.out_data),  (qa.size() != 0) ? qa[0] : 128'd0);
      chk("rndA_ready", 128'(busA.in_ready),  128'(qa.size() < 2));
      chk("rndA_occ",   128'(busA.occupancy), 128'(qa.size()));
      if (stallA) chk("rndA_stable", 128'(busA.out_data), prevA);
      if (busA.occupancy < 2'd2) chk("rndA_ready_occ", 128'(busA.in_ready), 128'd1);

      chk("rndB_valid", 128'(busB.out_valid), 128'(qb.size() != 0));
      chk("rndB_data",  128'(busB.out_data),  (qb.size() != 0) ? qb[0] : 128'd0);
      chk("rndB_ready", 128'(busB.in_ready),  128'(qb.size() < 2));
      chk("rndB_occ",   128'(busB.occupancy), 128'(qb.size()));
      if (stallB) chk("rndB_stable", 128'(busB.out_data), prevB);
      if (busB.occupancy < 2'd2) chk("rndB_ready_occ", 128'(busB.in_ready), 128'd1);

      ivA = ($urandom_range(0, 3) != 0);
      orA = ($urandom_range(0, 2) != 0);
      flA = ($urandom_range(0, 63) == 0);
      dA  = 128'($urandom);
      ivB = ($urandom_range(0, 1) != 0);
      orB = ($urandom_range(0, 3) == 0);
      flB = ($urandom_range(0, 63) == 0);
      r128 = {$urandom, $urandom, $urandom, $urandom};
      dB  = 128'(r128[106:0]);

      prevA  = 128'(busA.out_data);
      stallA = (qa.size() != 0) && !orA && !flA;
      prevB  = 128'(busB.out_data);
      stallB = (qb.size() != 0) && !orB && !flB;

      begin
        bit accA, accB;
        accA = ivA && (qa.size() < 2) && !flA;
        if ((qa.size() != 0) && orA) void'(qa.pop_front());
        if (flA) qa.delete();
        if (accA) qa.push_back(dA);
        accB = ivB && (qb.size() < 2) && !flB;
        if ((qb.size() != 0) && orB) void'(qb.pop_front());
        if (flB) qb.delete();
        if (accB) qb.push_back(dB);
      end

      busA.in_valid = ivA; busA.in_data = dA[31:0];  busA.out_ready = orA; busA.flush = flA;
      busB.in_valid = ivB; busB.in_data = dB[106:0]; busB.out_ready = orB; busB.flush = flB;
      stepClk();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
